// File: rtl/frame_counter.sv
// Frame-aware sample counter: tags each accepted sample with its global index,
// frame number and in-frame position, sign-extending the data to the output width.
module frame_counter #(
    parameter  int I_BW       = 14,
    parameter  int O_BW       = 16,
    parameter  int TOTAL_DATA = 15104,
    parameter  int FRAME_LEN  = 256,
    localparam int NUM_W      = $clog2(TOTAL_DATA),
    localparam int FRM_W      = $clog2((TOTAL_DATA + FRAME_LEN - 1) / FRAME_LEN + 1),
    localparam int POS_W      = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             di_en,
    input  logic [I_BW-1:0]  data_i,
    output logic             do_en,
    output logic [O_BW-1:0]  data_o,
    output logic [NUM_W-1:0] num,
    output logic [FRM_W-1:0] frame_idx,
    output logic [POS_W-1:0] pos,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [NUM_W-1:0] cnt_r;
    logic [POS_W-1:0] pos_cnt_r;
    logic [FRM_W-1:0] frm_cnt_r;

    logic             do_en_r;
    logic [O_BW-1:0]  data_r;
    logic [NUM_W-1:0] num_r;
    logic [FRM_W-1:0] frm_r;
    logic [POS_W-1:0] pos_r;
    logic             sof_r;
    logic             eof_r;
    logic             busy_r;
    logic             done_r;

    logic             last_s;
    logic             frame_end_s;

    function automatic logic [O_BW-1:0] sext(input logic [I_BW-1:0] d);
        sext = O_BW'($signed(d));
    endfunction

    // Terminal-count decodes on the counters that describe the next sample.
    always_comb begin
        last_s      = (cnt_r == NUM_W'(TOTAL_DATA - 1));
        frame_end_s = (pos_cnt_r == POS_W'(FRAME_LEN - 1));
    end

    // Capture FSM with counters and registered output tagging.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            pos_cnt_r <= '0;
            frm_cnt_r <= '0;
            do_en_r   <= 1'b0;
            data_r    <= '0;
            num_r     <= '0;
            frm_r     <= '0;
            pos_r     <= '0;
            sof_r     <= 1'b0;
            eof_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            do_en_r <= 1'b0;
            sof_r   <= 1'b0;
            eof_r   <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // A start never accepts the sample presented in the same cycle.
                    if (start) begin
                        state_r   <= ST_RUN;
                        cnt_r     <= '0;
                        pos_cnt_r <= '0;
                        frm_cnt_r <= '0;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                    end else begin
                        busy_r    <= 1'b0;
                        done_r    <= (state_r == ST_DONE);
                    end
                end
                ST_RUN: begin
                    if (di_en) begin
                        do_en_r <= 1'b1;
                        data_r  <= sext(data_i);
                        num_r   <= cnt_r;
                        frm_r   <= frm_cnt_r;
                        pos_r   <= pos_cnt_r;
                        sof_r   <= (pos_cnt_r == '0);
                        eof_r   <= frame_end_s || last_s;
                        if (frame_end_s) begin
                            pos_cnt_r <= '0;
                            frm_cnt_r <= frm_cnt_r + FRM_W'(1);
                        end else begin
                            pos_cnt_r <= pos_cnt_r + POS_W'(1);
                        end
                        if (last_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r   <= cnt_r + NUM_W'(1);
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign do_en     = do_en_r;
    assign data_o    = data_r;
    assign num       = num_r;
    assign frame_idx = frm_r;
    assign pos       = pos_r;
    assign sof       = sof_r;
    assign eof       = eof_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_frame_counter.sv
// Self-checking bench for frame_counter: directed vector table, multi-cycle
// capture/restart sequences and randomized traffic against an index-arithmetic model.
module tb_frame_counter;

    localparam int IBW   = 14;
    localparam int OBW   = 16;
    localparam int TD    = 10;
    localparam int FL    = 4;
    localparam int NW    = $clog2(TD);
    localparam int FW    = $clog2((TD + FL - 1) / FL + 1);
    localparam int PW    = $clog2(FL);

    logic           clk;
    logic           rst;
    logic           start;
    logic           di_en;
    logic [IBW-1:0] data_i;
    logic           do_en;
    logic [OBW-1:0] data_o;
    logic [NW-1:0]  num;
    logic [FW-1:0]  frame_idx;
    logic [PW-1:0]  pos;
    logic           sof;
    logic           eof;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;

    frame_counter #(.I_BW(IBW), .O_BW(OBW), .TOTAL_DATA(TD), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .start(start), .di_en(di_en), .data_i(data_i),
        .do_en(do_en), .data_o(data_o), .num(num), .frame_idx(frame_idx), .pos(pos),
        .sof(sof), .eof(eof), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 capturing, 2 finished; acc = samples taken so far.
    int          m_phase = 0;
    int          m_acc   = 0;
    logic        m_do, m_sof, m_eof, m_busy, m_done;
    logic [15:0] m_data;
    int          m_num, m_frm, m_pos;

    task automatic model_step(input logic r, input logic s, input logic e, input logic [IBW-1:0] d);
        int k;
        int v;
        if (!r) begin
            m_phase = 0; m_acc = 0;
            m_do = 0; m_data = '0; m_num = 0; m_frm = 0; m_pos = 0;
            m_sof = 0; m_eof = 0; m_busy = 0; m_done = 0;
        end else begin
            m_do = 0; m_sof = 0; m_eof = 0;
            if (m_phase == 1 && e) begin
                k = m_acc;
                v = int'(d);
                if (v >= (1 << (IBW - 1))) v = v - (1 << IBW);
                m_do   = 1;
                m_data = 16'(v);
                m_num  = k;
                m_frm  = k / FL;
                m_pos  = k % FL;
                m_sof  = (k % FL == 0);
                m_eof  = (k % FL == FL - 1) || (k == TD - 1);
                m_acc  = m_acc + 1;
                if (m_acc == TD) m_phase = 2;
            end else if (m_phase != 1 && s) begin
                m_phase = 1;
                m_acc   = 0;
            end
            m_busy = (m_phase == 1);
            m_done = (m_phase == 2);
        end
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic cmp_all(input int idx, input logic e_do, input logic [15:0] e_data, input int e_num,
                           input int e_frm, input int e_pos, input logic e_sof, input logic e_eof,
                           input logic e_busy, input logic e_done);
        chk("do_en", idx, 32'(do_en), 32'(e_do));
        chk("data_o", idx, 32'(data_o), 32'(e_data));
        chk("num", idx, 32'(num), 32'(e_num));
        chk("frame_idx", idx, 32'(frame_idx), 32'(e_frm));
        chk("pos", idx, 32'(pos), 32'(e_pos));
        chk("sof", idx, 32'(sof), 32'(e_sof));
        chk("eof", idx, 32'(eof), 32'(e_eof));
        chk("busy", idx, 32'(busy), 32'(e_busy));
        chk("done", idx, 32'(done), 32'(e_done));
    endtask

    task automatic drive(input logic r, input logic s, input logic e, input logic [IBW-1:0] d);
        rst = r; start = s; di_en = e; data_i = d;
        model_step(r, s, e, d);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input int idx);
        cmp_all(idx, m_do, m_data, m_num, m_frm, m_pos, m_sof, m_eof, m_busy, m_done);
    endtask

    typedef struct {
        logic        r, s, e;
        logic [13:0] d;
        logic        x_do;
        logic [15:0] x_data;
        int          x_num, x_frm, x_pos;
        logic        x_sof, x_eof, x_busy, x_done;
    } vec_t;

    function automatic vec_t mkv(logic r, logic s, logic e, logic [13:0] d, logic xd, logic [15:0] xdat,
                                 int xn, int xf, int xp, logic xs, logic xe, logic xb, logic xdn);
        vec_t v;
        v.r = r; v.s = s; v.e = e; v.d = d;
        v.x_do = xd; v.x_data = xdat; v.x_num = xn; v.x_frm = xf; v.x_pos = xp;
        v.x_sof = xs; v.x_eof = xe; v.x_busy = xb; v.x_done = xdn;
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        int sofs;
        int eofs;
        int idx;
        rst = 1'b0; start = 1'b0; di_en = 1'b0; data_i = '0;

        //             rst   start di_en data      do    data_o   num frm pos sof   eof   busy  done
        vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mkv(1'b1, 1'b1, 1'b1, 14'h2000, 1'b0, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mkv(1'b1, 1'b0, 1'b1, 14'h2000, 1'b1, 16'hE000, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mkv(1'b1, 1'b0, 1'b1, 14'h1FFF, 1'b1, 16'h1FFF, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 14'h0AAA, 1'b0, 16'h1FFF, 1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mkv(1'b1, 1'b1, 1'b1, 14'h0005, 1'b1, 16'h0005, 2, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mkv(1'b1, 1'b0, 1'b1, 14'h3FFF, 1'b1, 16'hFFFF, 3, 0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mkv(1'b1, 1'b0, 1'b1, 14'h0123, 1'b1, 16'h0123, 4, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mkv(1'b0, 1'b0, 1'b1, 14'h0777, 1'b0, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mkv(1'b1, 1'b0, 1'b1, 14'h0777, 1'b0, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mkv(1'b0, 1'b1, 1'b1, 14'h0777, 1'b0, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].d);
            cmp_all(i, vecs[i].x_do, vecs[i].x_data, vecs[i].x_num, vecs[i].x_frm, vecs[i].x_pos,
                    vecs[i].x_sof, vecs[i].x_eof, vecs[i].x_busy, vecs[i].x_done);
        end
        // Reset released with di_en high but no start: still idle.
        drive(1'b1, 1'b0, 1'b1, 14'h0111);
        cmp_all(11, 1'b0, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full contiguous capture, overrun in DONE, restart from DONE.
        idx  = 100;
        sofs = 0;
        eofs = 0;
        drive(1'b1, 1'b1, 1'b0, 14'h0000);
        cmp_model(idx++);
        for (int i = 0; i < TD; i++) begin
            drive(1'b1, 1'b0, 1'b1, 14'($urandom));
            cmp_model(idx++);
            if (do_en && sof) sofs++;
            if (do_en && eof) eofs++;
        end
        chk("sof_count", 0, 32'(sofs), 32'd3);
        chk("eof_count", 0, 32'(eofs), 32'd3);
        chk("done_after_capture", 0, 32'(done), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 14'($urandom));
            cmp_model(idx++);
        end
        drive(1'b1, 1'b1, 1'b1, 14'h0042);
        cmp_model(idx++);
        chk("busy_after_restart", 0, 32'(busy), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 14'h0042);
        cmp_model(idx++);
        chk("restart_num", 0, 32'(num), 32'd0);
        chk("restart_sof", 0, 32'(sof), 32'd1);

        // Gapped input pattern.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, ((i % 2) == 0), 14'($urandom));
            cmp_model(idx++);
        end

        // Randomized traffic including occasional resets and starts.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 1), 14'($urandom));
            cmp_model(1000 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
